// File: rtl/uart_hex_tx_pkg.sv
// rtl/uart_hex_tx_pkg.sv - ASCII constants, FSM states and hex digit helper
package uart_hex_tx_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_a  = 8'h61;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRIG    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  // Render one nibble as an ASCII hex digit, upper or lower case letters.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n, input logic upper);
    logic [7:0] n8;
    n8 = {4'h0, n};
    if (n < 4'd10) begin
      return ASCII_0 + n8;
    end
    return (upper ? ASCII_A : ASCII_a) + n8 - 8'd10;
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// rtl/uart_word_fifo.sv - 32-bit synchronous FIFO with first-word-fall-through head
module uart_word_fifo #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Pushes while full and pops while empty are ignored; pointers wrap naturally.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_hex_tx.sv
// rtl/uart_hex_tx.sv - formats queued 32-bit words as ASCII hex for the UART Tx stage
module uart_hex_tx
  import uart_hex_tx_pkg::*;
#(
  parameter int FIFO_AW   = 2,
  parameter bit UPPERCASE = 1'b1,
  parameter bit TERM_CRLF = 1'b1
) (
  input  logic               clkuart,
  input  logic               reset,
  input  logic [31:0]        word_in,
  input  logic               word_valid,
  output logic               word_ready,
  output logic [7:0]         tx_data,
  output logic               tx_trig,
  input  logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               idle,
  output logic               overflow
);

  localparam logic [3:0] LAST_IDX = TERM_CRLF ? 4'd9 : 4'd8;

  state_e      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_trig_q, tx_trig_d;
  logic        overflow_q, overflow_d;

  logic [31:0] fifo_head;
  logic        fifo_full, fifo_empty, pop;
  logic [3:0]  idx_next;

  // Character at index i: eight digits taken from the top of the shift register, then terminator(s).
  function automatic logic [7:0] char_at(input logic [3:0] i, input logic [31:0] sh);
    if (i < 4'd8) return nibble_to_ascii(sh[31:28], UPPERCASE);
    if (i == 4'd8) return TERM_CRLF ? ASCII_CR : ASCII_SP;
    return ASCII_LF;
  endfunction

  assign pop      = (state_q == IDLE) & ~fifo_empty;
  assign idx_next = idx_q + 4'd1;

  uart_word_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (clkuart),
    .resetn  (reset),
    .wr_en   (word_valid),
    .wr_data (word_in),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign word_ready = ~fifo_full;
  assign idle       = (state_q == IDLE) & fifo_empty;
  assign tx_data    = tx_data_q;
  assign tx_trig    = tx_trig_q;
  assign overflow   = overflow_q;

  // Character sequencer: pop a word, then trigger/wait busy high/wait busy low per character.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_trig_d  = 1'b0;
    overflow_d = overflow_q | (word_valid & fifo_full);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          tx_data_d = nibble_to_ascii(fifo_head[31:28], UPPERCASE);
          shift_d   = fifo_head << 4;
          idx_d     = 4'd0;
          tx_trig_d = 1'b1;
          state_d   = TRIG;
        end
      end
      TRIG: state_d = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q != LAST_IDX) begin
            idx_d     = idx_next;
            tx_data_d = char_at(idx_next, shift_q);
            if (idx_next < 4'd8) shift_d = shift_q << 4;
            tx_trig_d = 1'b1;
            state_d   = TRIG;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clkuart) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_trig_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_trig_q  <= tx_trig_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_hex_tx.sv
// tb/tb_uart_hex_tx.sv - randomized self-checking bench for uart_hex_tx against a string-based reference
module tb_uart_hex_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] word_in;
  logic        word_valid_u, word_valid_l;

  logic        word_ready_u, word_ready_l;
  logic [7:0]  tx_data_u, tx_data_l;
  logic        tx_trig_u, tx_trig_l;
  logic        tx_busy_u = 1'b0, tx_busy_l = 1'b0;
  logic [2:0]  fifo_count_u, fifo_count_l;
  logic        idle_u, idle_l;
  logic        overflow_u, overflow_l;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got_u[$], got_l[$], exp_u[$], exp_l[$];
  int busy_cnt_u = 0, busy_cnt_l = 0;
  int trig_total_u = 0, trig_total_l = 0;
  logic prev_trig_u = 1'b0, prev_trig_l = 1'b0;

  always #5 clk = ~clk;

  uart_hex_tx dut_u (
    .clkuart    (clk),
    .reset      (rst_n),
    .word_in    (word_in),
    .word_valid (word_valid_u),
    .word_ready (word_ready_u),
    .tx_data    (tx_data_u),
    .tx_trig    (tx_trig_u),
    .tx_busy    (tx_busy_u),
    .fifo_count (fifo_count_u),
    .idle       (idle_u),
    .overflow   (overflow_u)
  );

  uart_hex_tx #(.FIFO_AW(2), .UPPERCASE(1'b0), .TERM_CRLF(1'b0)) dut_l (
    .clkuart    (clk),
    .reset      (rst_n),
    .word_in    (word_in),
    .word_valid (word_valid_l),
    .word_ready (word_ready_l),
    .tx_data    (tx_data_l),
    .tx_trig    (tx_trig_l),
    .tx_busy    (tx_busy_l),
    .fifo_count (fifo_count_l),
    .idle       (idle_l),
    .overflow   (overflow_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference rendering: printf the word as hex text, fold case, then add terminator(s).
  function automatic logic [7:0] ref_char(input logic [31:0] w, input int i, input bit upper, input bit crlf);
    string s;
    logic [7:0] c;
    s = $sformatf("%08x", w);
    if (i < 8) begin
      c = s[i];
      if (upper && c >= 8'h61) c = c - 8'h20;
      return c;
    end
    if (!crlf) return 8'h20;
    return (i == 8) ? 8'h0D : 8'h0A;
  endfunction

  // Behavioural Tx stage: busy rises the edge after the trigger and lasts 153 cycles.
  always @(posedge clk) begin
    if (tx_trig_u) begin
      check("trig_while_busy_u", 32'(tx_busy_u), 32'd0);
      check("trig_back_to_back_u", 32'(prev_trig_u), 32'd0);
      got_u.push_back(tx_data_u);
      trig_total_u++;
      busy_cnt_u = 153;
      tx_busy_u <= 1'b1;
    end else if (busy_cnt_u > 0) begin
      busy_cnt_u--;
      if (busy_cnt_u == 0) tx_busy_u <= 1'b0;
    end
    prev_trig_u = tx_trig_u;
  end

  always @(posedge clk) begin
    if (tx_trig_l) begin
      check("trig_while_busy_l", 32'(tx_busy_l), 32'd0);
      check("trig_back_to_back_l", 32'(prev_trig_l), 32'd0);
      got_l.push_back(tx_data_l);
      trig_total_l++;
      busy_cnt_l = 153;
      tx_busy_l <= 1'b1;
    end else if (busy_cnt_l > 0) begin
      busy_cnt_l--;
      if (busy_cnt_l == 0) tx_busy_l <= 1'b0;
    end
    prev_trig_l = tx_trig_l;
  end

  // Drive one push for one cycle, starting and ending at a falling edge.
  task automatic push_word(input logic [31:0] w, input bit to_u, input bit to_l, input bit exp_acc);
    word_in = w;
    word_valid_u = to_u;
    word_valid_l = to_l;
    if (to_u) check("push_ready_u", 32'(word_ready_u), 32'(exp_acc));
    if (to_l) check("push_ready_l", 32'(word_ready_l), 32'(exp_acc));
    if (exp_acc) begin
      for (int i = 0; i < 10; i++) if (to_u) exp_u.push_back(ref_char(w, i, 1'b1, 1'b1));
      for (int i = 0; i < 9; i++)  if (to_l) exp_l.push_back(ref_char(w, i, 1'b0, 1'b0));
    end
    @(negedge clk);
    word_valid_u = 1'b0;
    word_valid_l = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (idle_u && idle_l && !tx_busy_u && !tx_busy_l) begin
        done = 1;
        break;
      end
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  // Wait until dut_u has emitted `target` characters in total and the Tx stage went idle.
  task automatic wait_char_done(input int target);
    bit done = 0;
    for (int k = 0; k < 20000; k++) begin
      if (trig_total_u >= target && !tx_busy_u) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    if (!done) check("char_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_streams(input string tag);
    check({tag, "_len_u"}, 32'(got_u.size()), 32'(exp_u.size()));
    for (int i = 0; i < got_u.size() && i < exp_u.size(); i++)
      check($sformatf("%s_u[%0d]", tag, i), 32'(got_u[i]), 32'(exp_u[i]));
    check({tag, "_len_l"}, 32'(got_l.size()), 32'(exp_l.size()));
    for (int i = 0; i < got_l.size() && i < exp_l.size(); i++)
      check($sformatf("%s_l[%0d]", tag, i), 32'(got_l[i]), 32'(exp_l[i]));
    got_u.delete(); exp_u.delete(); got_l.delete(); exp_l.delete();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_overflow_u", 32'(overflow_u), 32'd0);
    check("rst_count_u", 32'(fifo_count_u), 32'd0);
  endtask

  initial begin
    int base;
    logic [31:0] w;
    rst_n = 1'b0;
    word_in = $urandom;
    word_valid_u = 1'b1;
    word_valid_l = 1'b1;

    // Reset held with word_valid asserted.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_trig_u", 32'(tx_trig_u), 32'd0);
      check("rst_count_u", 32'(fifo_count_u), 32'd0);
      check("rst_overflow_u", 32'(overflow_u), 32'd0);
      check("rst_idle_u", 32'(idle_u), 32'd1);
      check("rst_data_u", 32'(tx_data_u), 32'h00);
      check("rst_ready_l", 32'(word_ready_l), 32'd1);
    end
    rst_n = 1'b1;
    word_valid_u = 1'b0;
    word_valid_l = 1'b0;
    @(negedge clk);
    check("post_rst_idle_u", 32'(idle_u), 32'd1);
    check("post_rst_ready_u", 32'(word_ready_u), 32'd1);
    check("post_rst_count_u", 32'(fifo_count_u), 32'd0);
    check("post_rst_trig_u", 32'(tx_trig_u), 32'd0);

    // Single word, upper case with CR LF.
    base = trig_total_u;
    push_word(32'h1234ABCD, 1'b1, 1'b0, 1'b1);
    drain(5000);
    check("single_trig_count", 32'(trig_total_u - base), 32'd10);
    compare_streams("single");

    // Lower case with space terminator.
    base = trig_total_l;
    push_word(32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    drain(5000);
    check("lower_trig_count", 32'(trig_total_l - base), 32'd9);
    compare_streams("lower");

    // Random bursts of up to four words into both formatters.
    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        push_word($urandom, 1'b1, 1'b1, 1'b1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain(20000);
      compare_streams($sformatf("rand%0d", r));
    end

    // Fill the FIFO behind a printing word, then overflow it.
    push_word($urandom, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("fill_popped_count", 32'(fifo_count_u), 32'd0);
    for (int k = 0; k < 4; k++) push_word($urandom, 1'b1, 1'b0, 1'b1);
    check("fill_count", 32'(fifo_count_u), 32'd4);
    check("fill_ready", 32'(word_ready_u), 32'd0);
    check("fill_overflow_before", 32'(overflow_u), 32'd0);
    push_word(32'hBAD0BAD0, 1'b1, 1'b0, 1'b0);
    check("fill_overflow_after", 32'(overflow_u), 32'd1);
    check("fill_count_after_drop", 32'(fifo_count_u), 32'd4);
    drain(20000);
    compare_streams("fill");

    // Push in the cycle the FSM pops: dropped when full, accepted at count 3.
    pulse_reset();
    base = trig_total_u;
    push_word($urandom, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) push_word($urandom, 1'b1, 1'b0, 1'b1);
    wait_char_done(base + 10);
    @(negedge clk);
    push_word(32'hDEAD0001, 1'b1, 1'b0, 1'b0);
    check("popcycle_full_count", 32'(fifo_count_u), 32'd3);
    check("popcycle_full_overflow", 32'(overflow_u), 32'd1);
    wait_char_done(base + 20);
    @(negedge clk);
    w = $urandom;
    push_word(w, 1'b1, 1'b0, 1'b1);
    check("popcycle_three_count", 32'(fifo_count_u), 32'd3);
    drain(30000);
    compare_streams("popcycle");

    // Reset after the fourth character aborts the word.
    pulse_reset();
    base = trig_total_u;
    push_word(32'h00000000, 1'b1, 1'b0, 1'b1);
    wait_char_done(base + 4);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_u.delete();
    for (int k = 0; k < 4; k++) exp_u.push_back(8'h30);
    base = trig_total_u;
    repeat (400) @(negedge clk);
    check("abort_no_trig", 32'(trig_total_u - base), 32'd0);
    check("abort_count", 32'(fifo_count_u), 32'd0);
    check("abort_idle", 32'(idle_u), 32'd1);
    compare_streams("abort");
    push_word(32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
    drain(5000);
    compare_streams("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
